// File: rtl/emu_host_master.sv
// emu_host_master: host-side sequencer that writes stimulus bytes to an emulation wrapper,
// pulses a generated DUT clock nclk times, then reads the DUT output bytes back.
`default_nettype none

module emu_host_master #(
  parameter int NUM_STIM = 1,
  parameter int NUM_OUT  = 3,
  parameter int DUT_HALF = 2
) (
  input  logic                  clk_emu,
  input  logic                  nrst_emu,
  input  logic [NUM_STIM*8-1:0] stim_data,
  input  logic [3:0]            nclk,
  input  logic                  stim_valid,
  output logic                  stim_ready,
  output logic [NUM_OUT*8-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            Din_emu,
  output logic [2:0]            Addr_emu,
  output logic                  load_emu,
  output logic                  get_emu,
  input  logic [7:0]            Dout_emu,
  output logic                  clk_dut,
  output logic                  busy
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] WRITE = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] CLKHI = 3'd3;
  localparam logic [2:0] CLKLO = 3'd4;
  localparam logic [2:0] GET   = 3'd5;
  localparam logic [2:0] READ  = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

  logic [2:0]            state;
  logic [2:0]            next_state;
  logic [3:0]            cnt;
  logic [3:0]            pulses;
  logic [NUM_STIM*8-1:0] stim_q;
  logic                  last_write;
  logic                  last_half;
  logic                  last_read;

  assign last_write = (cnt == 4'(NUM_STIM - 1));
  assign last_half  = (cnt == 4'(DUT_HALF - 1));
  assign last_read  = (cnt == 4'(NUM_OUT));

  always_ff @(posedge clk_emu or negedge nrst_emu) begin
    if (!nrst_emu) state <= IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (stim_valid) next_state = WRITE;
      WRITE:   if (last_write) next_state = LOAD;
      LOAD:    next_state = (pulses != 4'd0) ? CLKHI : GET;
      CLKHI:   if (last_half) next_state = CLKLO;
      CLKLO:   if (last_half) next_state = (pulses > 4'd1) ? CLKHI : GET;
      GET:     next_state = READ;
      READ:    if (last_read) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // cnt restarts on every state change, so it indexes bytes and half-period cycles alike
  always_ff @(posedge clk_emu or negedge nrst_emu) begin
    if (!nrst_emu) begin
      cnt      <= 4'd0;
      pulses   <= 4'd0;
      stim_q   <= '0;
      out_data <= '0;
      clk_dut  <= 1'b0;
    end else begin
      clk_dut <= (next_state == CLKHI);
      cnt     <= (next_state != state) ? 4'd0 : cnt + 4'd1;
      if (state == IDLE && stim_valid) begin
        stim_q <= stim_data;
        pulses <= nclk;
      end
      if (state == CLKLO && last_half && pulses != 4'd0)
        pulses <= pulses - 4'd1;
      // wrapper output lags Addr_emu by one edge
      if (state == READ) begin
        for (int j = 0; j < NUM_OUT; j++)
          if (cnt == 4'(j + 1)) out_data[8*j +: 8] <= Dout_emu;
      end
    end
  end

  always_comb begin
    stim_ready = (state == IDLE);
    busy       = (state != IDLE) && (state != DONE);
    out_valid  = (state == DONE);
    load_emu   = (state == LOAD);
    get_emu    = (state == GET);
    Din_emu    = 8'd0;
    Addr_emu   = 3'd0;
    if (state == WRITE) begin
      Addr_emu = cnt[2:0];
      for (int j = 0; j < NUM_STIM; j++)
        if (cnt == 4'(j)) Din_emu = stim_q[8*j +: 8];
    end
    if (state == READ && cnt < 4'(NUM_OUT))
      Addr_emu = cnt[2:0];
  end

endmodule

`default_nettype wire

// File: tb/tb_emu_host_master.sv
// tb_emu_host_master: randomized self-checking bench; one default instance and one 4-in/8-out instance.
`default_nettype none

module tb_emu_host_master;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [31:0] stim_data = '0;
  logic [3:0]  nclk = '0;
  logic        valid_a = 1'b0, valid_b = 1'b0, out_ready = 1'b0;
  logic        sel = 1'b0;

  logic        ready_a, ovalid_a, load_a, get_a, clk_a, busy_a;
  logic        ready_b, ovalid_b, load_b, get_b, clk_b, busy_b;
  logic [23:0] out_data_a;
  logic [63:0] out_data_b;
  logic [7:0]  din_a, din_b, dout_a, dout_b;
  logic [2:0]  addr_a, addr_b;
  logic [7:0]  mem [0:1][0:7];

  int          n_cmp = 0;
  int          n_err = 0;
  logic [63:0] cur_data;
  int          cur_n;

  always #5 clk = ~clk;

  emu_host_master dut_a (
    .clk_emu(clk), .nrst_emu(nrst), .stim_data(stim_data[7:0]), .nclk(nclk),
    .stim_valid(valid_a), .stim_ready(ready_a), .out_data(out_data_a), .out_valid(ovalid_a),
    .out_ready(out_ready), .Din_emu(din_a), .Addr_emu(addr_a), .load_emu(load_a),
    .get_emu(get_a), .Dout_emu(dout_a), .clk_dut(clk_a), .busy(busy_a)
  );

  emu_host_master #(.NUM_STIM(4), .NUM_OUT(8), .DUT_HALF(2)) dut_b (
    .clk_emu(clk), .nrst_emu(nrst), .stim_data(stim_data), .nclk(nclk),
    .stim_valid(valid_b), .stim_ready(ready_b), .out_data(out_data_b), .out_valid(ovalid_b),
    .out_ready(out_ready), .Din_emu(din_b), .Addr_emu(addr_b), .load_emu(load_b),
    .get_emu(get_b), .Dout_emu(dout_b), .clk_dut(clk_b), .busy(busy_b)
  );

  // wrapper model: registered read of its output array
  always @(posedge clk) begin
    dout_a <= mem[0][addr_a];
    dout_b <= mem[1][addr_b];
  end

  // observed vector: {busy, ready, valid, clk_dut, load, get, addr[2:0], din[7:0]}
  logic [16:0] obs;
  logic [63:0] odata;
  logic        oclk;
  assign obs   = sel ? {busy_b, ready_b, ovalid_b, clk_b, load_b, get_b, addr_b, din_b}
                     : {busy_a, ready_a, ovalid_a, clk_a, load_a, get_a, addr_a, din_a};
  assign odata = sel ? out_data_b : {40'd0, out_data_a};
  assign oclk  = sel ? clk_b : clk_a;

  localparam logic [16:0] IDLE_VEC = 17'h08000;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // expected outputs s cycles after the accept edge, from the transaction schedule
  function automatic logic [16:0] exp_vec(input int s, input bit b, input int n, input logic [63:0] data);
    int ns, no, g, d, ph;
    logic busy_e, valid_e, clk_e, load_e, get_e;
    logic [2:0] addr_e;
    logic [7:0] din_e;
    ns = b ? 4 : 1;
    no = b ? 8 : 3;
    g  = ns + 1 + 4 * n;
    d  = g + no + 2;
    ph = s - ns - 1;
    busy_e  = (s < d);
    valid_e = (s == d);
    load_e  = (s == ns);
    get_e   = (s == g);
    clk_e   = (s > ns) && (s < g) && ((ph % 4) < 2);
    addr_e  = 3'd0;
    din_e   = 8'd0;
    if (s < ns) begin
      addr_e = 3'(s);
      din_e  = data[8*s +: 8];
    end else if (s > g && (s - g - 1) < no) begin
      addr_e = 3'(s - g - 1);
    end
    return {busy_e, 1'b0, valid_e, clk_e, load_e, get_e, addr_e, din_e};
  endfunction

  function automatic logic [63:0] exp_out(input bit b);
    logic [63:0] r = '0;
    for (int j = 0; j < (b ? 8 : 3); j++) r[8*j +: 8] = mem[b][j];
    return r;
  endfunction

  task automatic rand_mem(input bit b);
    for (int j = 0; j < 8; j++) mem[b][j] = 8'($urandom);
  endtask

  task automatic start_txn(input bit b, input int n, input logic [63:0] data);
    sel = b;
    @(negedge clk);
    check("idle_before_accept", obs, IDLE_VEC);
    cur_data  = data;
    cur_n     = n;
    stim_data = data[31:0];
    nclk      = 4'(n);
    out_ready = 1'b0;
    if (b) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    #1;
    valid_a   = 1'b0;
    valid_b   = 1'b0;
    stim_data = $urandom;
    nclk      = 4'($urandom);
  endtask

  task automatic finish_txn(input int hold);
    bit   b = sel;
    int   d, first_v, rises;
    logic prev;
    d       = (b ? 4 : 1) + 2 + 4 * cur_n + (b ? 8 : 3) + 1;
    first_v = -1;
    rises   = 0;
    prev    = 1'b0;
    for (int s = 0; s <= d; s++) begin
      @(negedge clk);
      check($sformatf("cycle%0d", s), obs, exp_vec(s, b, cur_n, cur_data));
      if (oclk && !prev) rises++;
      prev = oclk;
      if (obs[14] && first_v < 0) first_v = s;
      if (b) valid_b = 1'($urandom); else valid_a = 1'($urandom);
      stim_data = $urandom;
    end
    check("latency", 64'(first_v), 64'(d));
    check("clk_dut_rises", 64'(rises), 64'(cur_n));
    check("out_data", odata, exp_out(b));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 64'(obs[14]), 64'd1);
      check("hold_ready", 64'(obs[15]), 64'd0);
      check("hold_data", odata, exp_out(b));
      if (b) valid_b = 1'($urandom); else valid_a = 1'($urandom);
    end
    out_ready = 1'b1;
    valid_a   = 1'b0;
    valid_b   = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < 8; j++) mem[b][j] = 8'd0;

    repeat (2) @(negedge clk);
    check("reset_a", obs, IDLE_VEC);
    check("reset_a_data", odata, 64'd0);
    sel = 1'b1;
    #1;
    check("reset_b", obs, IDLE_VEC);
    check("reset_b_data", odata, 64'd0);
    sel = 1'b0;
    @(negedge clk);
    nrst = 1'b1;

    // reference transaction: 0x35, one pulse, wrapper returns 01 00 00
    mem[0][0] = 8'h01; mem[0][1] = 8'h00; mem[0][2] = 8'h00;
    start_txn(1'b0, 1, 64'h35);
    finish_txn(0);

    rand_mem(1'b0);
    start_txn(1'b0, 0, {32'd0, $urandom});
    finish_txn(1);

    rand_mem(1'b0);
    start_txn(1'b0, 15, {32'd0, $urandom});
    finish_txn(5);

    // reset while the DUT clock is high
    rand_mem(1'b0);
    start_txn(1'b0, 3, {32'd0, $urandom});
    for (int k = 0; k < 50 && oclk !== 1'b1; k++) @(negedge clk);
    check("reach_clkhi", 64'(oclk), 64'd1);
    @(posedge clk);
    #1 check("clk_high_before_reset", 64'(oclk), 64'd1);
    nrst = 1'b0;
    #1;
    check("async_reset_vec", obs, IDLE_VEC);
    check("async_reset_data", odata, 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("in_reset_vec", obs, IDLE_VEC);
    end
    @(negedge clk);
    nrst = 1'b1;
    rand_mem(1'b0);
    start_txn(1'b0, 1, {32'd0, $urandom});
    finish_txn(0);

    for (int t = 0; t < 6; t++) begin
      rand_mem(1'b0);
      start_txn(1'b0, int'($urandom_range(0, 15)), {32'd0, $urandom});
      finish_txn(int'($urandom_range(0, 3)));
    end

    rand_mem(1'b1);
    start_txn(1'b1, 2, 64'hA1B2C3D4);
    finish_txn(2);

    for (int t = 0; t < 3; t++) begin
      rand_mem(1'b1);
      start_txn(1'b1, int'($urandom_range(0, 15)), {32'd0, $urandom});
      finish_txn(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/emu_host_master.md
EMU_HOST_MASTER -- requirements
Module: emu_host_master

Interface
REQ-001 Parameter NUM_STIM, default 1, number of stimulus bytes written per transaction (legal 1..8).
REQ-002 Parameter NUM_OUT, default 3, number of output bytes read back per transaction (legal 1..8).
REQ-003 Parameter DUT_HALF, default 2, clk_emu cycles per clk_dut high phase and per low phase (legal 1..15).
REQ-004 Port clk_emu  in  1  emulation clock; all logic on its rising edge.
REQ-005 Port nrst_emu  in  1  reset, asynchronous, active-low.
REQ-006 Port stim_data  in  NUM_STIM*8  stimulus vector; byte i = bits [8i+7:8i].
REQ-007 Port nclk  in  4  number of clk_dut pulses per transaction (0..15).
REQ-008 Port stim_valid  in  1  host request valid.
REQ-009 Port stim_ready  out  1  block can accept a request.
REQ-010 Port out_data  out  NUM_OUT*8  captured DUT output vector; byte j = bits [8j+7:8j].
REQ-011 Port out_valid  out  1  out_data valid.
REQ-012 Port out_ready  in  1  host consumes out_data.
REQ-013 Port Din_emu  out  8  byte to wrapper stimulus array.
REQ-014 Port Addr_emu  out  3  wrapper array index.
REQ-015 Port load_emu  out  1  wrapper: apply stimulus to DUT.
REQ-016 Port get_emu  out  1  wrapper: capture DUT outputs.
REQ-017 Port Dout_emu  in  8  wrapper output byte, registered in the wrapper (valid one clk_emu edge after Addr_emu).
REQ-018 Port clk_dut  out  1  generated DUT clock, registered, glitch-free.
REQ-019 Port busy  out  1  high in every state except IDLE and DONE.

Function
REQ-020 FSM states SHALL be IDLE, WRITE, LOAD, CLKHI, CLKLO, GET, READ, DONE.
REQ-021 IDLE: stim_ready=1; on stim_valid&&stim_ready, capture stim_data and nclk, go WRITE.
REQ-022 WRITE: NUM_STIM cycles; in cycle i drive Addr_emu=i, Din_emu=byte i; then LOAD.
REQ-023 LOAD: load_emu=1 for exactly one cycle; next state CLKHI if nclk!=0, else GET.
REQ-024 CLKHI: clk_dut=1 for DUT_HALF cycles, then CLKLO; CLKLO: clk_dut=0 for DUT_HALF cycles, decrement pulse counter, then CLKHI if pulses remain, else GET.
REQ-025 GET: get_emu=1 for exactly one cycle, then READ.
REQ-026 READ: NUM_OUT+1 cycles; cycle k (k<NUM_OUT) drives Addr_emu=k; at the edge ending cycle k+1, Dout_emu is stored as out_data byte k (k<NUM_OUT).
REQ-027 DONE: out_valid=1, out_data stable, until out_ready sampled high; then out_valid=0 and IDLE the next cycle.
REQ-028 load_emu and get_emu SHALL never be high together, and neither SHALL be high in WRITE, READ, CLKHI or CLKLO.
REQ-029 clk_dut SHALL be 0 in every state except CLKHI.
REQ-030 Outside WRITE, Din_emu=0; outside WRITE/READ, Addr_emu=0.
REQ-031 Accept-to-out_valid latency SHALL be NUM_STIM + 2 + 2*DUT_HALF*nclk + NUM_OUT + 1 cycles (defaults, nclk=1: 11).
REQ-032 stim_valid while not in IDLE SHALL be ignored (stim_ready=0); stim_data changes after accept SHALL not affect the transaction.
REQ-033 out_ready high before DONE SHALL have no effect; back-to-back: a new request is accepted the cycle after DONE exits.
REQ-034 nclk=15 SHALL produce exactly 15 clk_dut rising edges; the pulse counter SHALL not wrap.

Reset
REQ-035 While nrst_emu=0: state IDLE, clk_dut=0, load_emu=0, get_emu=0, Din_emu=0, Addr_emu=0, out_valid=0, out_data=0, busy=0, stim_ready=1.
REQ-036 Reset asserted mid-transaction SHALL abort immediately (clk_dut forced 0 asynchronously) with no out_valid produced.

Verification
REQ-037 Defaults, stim_data=8'h35, nclk=1, wrapper model returns bytes 8'h01,8'h00,8'h00 -> one write Addr 0 Din 35, load pulse, one clk_dut pulse 2 high/2 low, get pulse, out_data=24'h000001, out_valid 11 cycles after accept.
REQ-038 nclk=0 -> no clk_dut edge, latency 7 cycles, get_emu follows load_emu by exactly one cycle.
REQ-039 nclk=15 -> exactly 15 clk_dut rising edges, each high 2 cycles and low 2 cycles.
REQ-040 out_ready held low 5 cycles in DONE -> out_valid and out_data stable; stim_valid during DONE ignored; accepted next cycle after out_ready.
REQ-041 nrst_emu pulsed low during CLKHI -> clk_dut falls without waiting for edge, all outputs at reset values, no out_valid; next request completes normally.
REQ-042 NUM_STIM=4, NUM_OUT=8, stim_data=32'hA1B2C3D4 -> writes Addr 0..3 = D4,C3,B2,A1 in order; 8 read bytes captured with correct one-cycle Dout_emu alignment.
